wb_stage_p: RTL and testbench

- Parametrised writeback stage with its own M→W pipeline register. It captures M-stage results and pre-decoded control fields.
- It performs load-data extension and selects the write-data source from DMout, ALU, link or HI/LO, and the destination register from rt, rd or $31.
- It drives the register-file write port and a bypass source for hazard forwarding.
- Adds behaviour the previous W stage lacks: stall/flush handling, byte/halfword loads, a HI/LO source, a configurable link offset and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/load_ext.sv | 35 +++
 rtl/wb_stage_p.sv | 177 +++++++++++++++++
 tb/tb_wb_stage_p.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: write-data sources, destination
// selects and load types.
package wb_pkg;

    // Write-data source select
    localparam logic [1:0] WD_DM   = 2'd0;
    localparam logic [1:0] WD_ALU  = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    // Destination register select (encodings 2 and 3 both mean $31)
    localparam logic [1:0] A3_RT = 2'd0;
    localparam logic [1:0] A3_RD = 2'd1;
    localparam logic [1:0] A3_RA = 2'd2;

    // Load types; any code above LD_HU behaves as a full-word load
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // Link register number
    localparam logic [4:0] RA_NUM = 5'd31;

endpackage

// File: rtl/load_ext.sv
// Load-data extension: picks a byte or halfword lane out of the raw memory
// word and sign- or zero-extends it to the datapath width.
module load_ext
    import wb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] raw_i,
    input  logic [2:0]    type_i,
    input  logic [1:0]    off_i,
    output logic [DW-1:0] ext_o
);

    logic [7:0]  lane_b_s;
    logic [15:0] lane_h_s;

    // Shifting instead of indexing keeps lane selection in range for any
    // legal DW; halfword lanes ignore the low offset bit on purpose, so a
    // misaligned halfword silently reads the enclosing aligned halfword.
    assign lane_b_s = 8'(raw_i >> {off_i, 3'b000});
    assign lane_h_s = 16'(raw_i >> {off_i[1], 4'b0000});

    // Extend the selected lane according to the load type
    always_comb begin
        ext_o = raw_i;
        case (type_i)
            LD_B:    ext_o = {{(DW-8){lane_b_s[7]}}, lane_b_s};
            LD_BU:   ext_o = {{(DW-8){1'b0}}, lane_b_s};
            LD_H:    ext_o = {{(DW-16){lane_h_s[15]}}, lane_h_s};
            LD_HU:   ext_o = {{(DW-16){1'b0}}, lane_h_s};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: M->W pipeline register with stall/flush, write-data and
// destination selection, register-file write port and a retired counter.
// The write port outputs depend only on the W registers.
module wb_stage_p
    import wb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_OFF = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [DW-1:0]    m_pc,
    input  logic [31:0]      m_instr,
    input  logic [DW-1:0]    m_alu,
    input  logic [DW-1:0]    m_dm,
    input  logic [DW-1:0]    m_hilo,
    input  logic [1:0]       m_wd_sel,
    input  logic [1:0]       m_a3_sel,
    input  logic             m_regwrite,
    input  logic [2:0]       m_load_type,
    input  logic [1:0]       m_byte_off,
    output logic             w_valid,
    output logic [DW-1:0]    w_pc,
    output logic             w_we,
    output logic [AW-1:0]    w_addr,
    output logic [DW-1:0]    w_wd,
    output logic [CNT_W-1:0] retired_cnt
);

    // W pipeline register, next state and current state
    logic             valid_d,     valid_q;
    logic [DW-1:0]    pc_d,        pc_q;
    logic [4:0]       rt_d,        rt_q;
    logic [4:0]       rd_d,        rd_q;
    logic [DW-1:0]    alu_d,       alu_q;
    logic [DW-1:0]    dm_d,        dm_q;
    logic [DW-1:0]    hilo_d,      hilo_q;
    logic [1:0]       wd_sel_d,    wd_sel_q;
    logic [1:0]       a3_sel_d,    a3_sel_q;
    logic             regwrite_d,  regwrite_q;
    logic [2:0]       load_type_d, load_type_q;
    logic [1:0]       byte_off_d,  byte_off_q;
    logic [CNT_W-1:0] cnt_d,       cnt_q;

    logic [DW-1:0]    ld_ext_s;

    // Only the register-number fields of the instruction are needed here
    logic             unused_instr_s;
    assign unused_instr_s = ^{m_instr[31:21], m_instr[10:0]};

    // Next state: flush inserts a zeroed bubble, stall holds, otherwise capture
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        dm_d        = dm_q;
        hilo_d      = hilo_q;
        wd_sel_d    = wd_sel_q;
        a3_sel_d    = a3_sel_q;
        regwrite_d  = regwrite_q;
        load_type_d = load_type_q;
        byte_off_d  = byte_off_q;
        cnt_d       = cnt_q;
        if (flush) begin
            valid_d     = 1'b0;
            pc_d        = {DW{1'b0}};
            rt_d        = 5'd0;
            rd_d        = 5'd0;
            alu_d       = {DW{1'b0}};
            dm_d        = {DW{1'b0}};
            hilo_d      = {DW{1'b0}};
            wd_sel_d    = WD_DM;
            a3_sel_d    = A3_RT;
            regwrite_d  = 1'b0;
            load_type_d = LD_W;
            byte_off_d  = 2'd0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d     = m_valid;
            pc_d        = m_pc;
            rt_d        = m_instr[20:16];
            rd_d        = m_instr[15:11];
            alu_d       = m_alu;
            dm_d        = m_dm;
            hilo_d      = m_hilo;
            wd_sel_d    = m_wd_sel;
            a3_sel_d    = m_a3_sel;
            // A bubble never writes, whatever its decoded control says
            regwrite_d  = m_regwrite & m_valid;
            load_type_d = m_load_type;
            byte_off_d  = m_byte_off;
            if (m_valid) begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= {DW{1'b0}};
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            alu_q       <= {DW{1'b0}};
            dm_q        <= {DW{1'b0}};
            hilo_q      <= {DW{1'b0}};
            wd_sel_q    <= WD_DM;
            a3_sel_q    <= A3_RT;
            regwrite_q  <= 1'b0;
            load_type_q <= LD_W;
            byte_off_q  <= 2'd0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            dm_q        <= dm_d;
            hilo_q      <= hilo_d;
            wd_sel_q    <= wd_sel_d;
            a3_sel_q    <= a3_sel_d;
            regwrite_q  <= regwrite_d;
            load_type_q <= load_type_d;
            byte_off_q  <= byte_off_d;
            cnt_q       <= cnt_d;
        end
    end

    load_ext #(.DW(DW)) u_load_ext (
        .raw_i  (dm_q),
        .type_i (load_type_q),
        .off_i  (byte_off_q),
        .ext_o  (ld_ext_s)
    );

    // Destination register from the stored instruction fields
    always_comb begin
        w_addr = AW'(RA_NUM);
        case (a3_sel_q)
            A3_RT:   w_addr = AW'(rt_q);
            A3_RD:   w_addr = AW'(rd_q);
            default: w_addr = AW'(RA_NUM);
        endcase
    end

    // Write-data source mux; link address wraps at the datapath width
    always_comb begin
        w_wd = ld_ext_s;
        case (wd_sel_q)
            WD_DM:   w_wd = ld_ext_s;
            WD_ALU:  w_wd = alu_q;
            WD_LINK: w_wd = pc_q + DW'(LINK_OFF);
            WD_HILO: w_wd = hilo_q;
            default: w_wd = ld_ext_s;
        endcase
    end

    // Writes to $0 are dropped here; the instruction still retires. Held
    // during stall so the same write repeats harmlessly.
    assign w_we        = valid_q & regwrite_q & (w_addr != {AW{1'b0}});
    assign w_valid     = valid_q;
    assign w_pc        = pc_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_p.sv
// Scoreboard bench for wb_stage_p: the driver predicts W-stage outputs from
// the behavioural rules and queues them; a monitor compares every cycle.
module tb_wb_stage_p;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            reset, stall, flush, m_valid, m_regwrite;
    logic [31:0]     m_pc, m_instr, m_alu, m_dm, m_hilo;
    logic [1:0]      m_wd_sel, m_a3_sel, m_byte_off;
    logic [2:0]      m_load_type;
    logic            w_valid, w_we;
    logic [31:0]     w_pc, w_wd;
    logic [AW-1:0]   w_addr;
    logic [CNT_W-1:0] retired_cnt;

    wb_stage_p #(.DW(DW), .AW(AW), .LINK_OFF(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_instr(m_instr), .m_alu(m_alu),
        .m_dm(m_dm), .m_hilo(m_hilo), .m_wd_sel(m_wd_sel), .m_a3_sel(m_a3_sel),
        .m_regwrite(m_regwrite), .m_load_type(m_load_type), .m_byte_off(m_byte_off),
        .w_valid(w_valid), .w_pc(w_pc), .w_we(w_we), .w_addr(w_addr),
        .w_wd(w_wd), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        int unsigned cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic done     = 1'b0;

    // Reference state: what the W stage architecturally holds
    logic        ref_v, ref_rw;
    logic [31:0] ref_pc, ref_wd;
    logic [4:0]  ref_addr;
    int unsigned ref_cnt;

    function automatic logic [31:0] ref_load(input logic [31:0] dm, input logic [2:0] t,
                                             input logic [1:0] off);
        int unsigned b, h;
        b = (dm >> (8 * off)) & 32'd255;
        h = (dm >> (16 * (off / 2))) & 32'd65535;
        case (t)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return dm;
        endcase
    endfunction

    function automatic logic [4:0] ref_dest(input logic [31:0] ins, input logic [1:0] sel);
        if (sel == 2'd0) return ins[20:16];
        if (sel == 2'd1) return ins[15:11];
        return 5'd31;
    endfunction

    function automatic logic [31:0] ref_data();
        case (m_wd_sel)
            2'd0:    return ref_load(m_dm, m_load_type, m_byte_off);
            2'd1:    return m_alu;
            2'd2:    return m_pc + 32'd8;
            default: return m_hilo;
        endcase
    endfunction

    // Predict the effect of the coming edge, queue it, then let the edge happen
    task automatic tick(input string tag);
        exp_t e;
        if (reset) begin
            ref_v = 1'b0; ref_rw = 1'b0; ref_pc = 32'd0; ref_wd = 32'd0;
            ref_addr = 5'd0; ref_cnt = 0;
        end else if (flush) begin
            ref_v = 1'b0; ref_rw = 1'b0; ref_pc = 32'd0; ref_wd = 32'd0;
            ref_addr = 5'd0;
        end else if (!stall) begin
            ref_v    = m_valid;
            ref_rw   = m_valid & m_regwrite;
            ref_pc   = m_pc;
            ref_addr = ref_dest(m_instr, m_a3_sel);
            ref_wd   = ref_data();
            if (m_valid) ref_cnt = (ref_cnt + 1) % 16;
        end
        e.v = ref_v; e.pc = ref_pc; e.addr = ref_addr; e.wd = ref_wd;
        e.we = ref_v & ref_rw & (ref_addr != 5'd0);
        e.cnt = ref_cnt; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req)
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, name, act, req);
        else
            n_pass++;
    endtask

    // Monitor: every sample point after an edge compares against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w_valid", e.tag, {31'd0, w_valid}, {31'd0, e.v});
                chk("w_pc",    e.tag, w_pc, e.pc);
                chk("w_we",    e.tag, {31'd0, w_we}, {31'd0, e.we});
                chk("w_addr",  e.tag, {27'd0, w_addr}, {27'd0, e.addr});
                chk("w_wd",    e.tag, w_wd, e.wd);
                chk("retired_cnt", e.tag, {28'd0, retired_cnt}, e.cnt);
            end
        end
    end

    task automatic set_op(input logic v, input logic rw, input logic [1:0] wd,
                          input logic [1:0] a3, input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] ins;
        ins = $urandom;
        ins[20:16] = rt;
        ins[15:11] = rd;
        m_instr = ins; m_valid = v; m_regwrite = rw; m_wd_sel = wd; m_a3_sel = a3;
        m_pc = $urandom; m_alu = $urandom; m_dm = $urandom; m_hilo = $urandom;
        m_load_type = 3'($urandom_range(0, 7)); m_byte_off = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [2:0] lt [6];
        logic [1:0] lo [6];
        lt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        lo = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        ref_v = 1'b0; ref_rw = 1'b0; ref_pc = 32'd0; ref_wd = 32'd0; ref_addr = 5'd0; ref_cnt = 0;
        set_op(1'b1, 1'b1, 2'd1, 2'd1, 5'd3, 5'd4);

        // Reset held with valid and stall high
        tick("reset0");
        tick("reset1");
        reset = 1'b0; stall = 1'b0;
        tick("first_capture");

        // Load extension table
        for (int i = 0; i < 6; i++) begin
            set_op(1'b1, 1'b1, 2'd0, 2'd0, 5'd9, 5'd17);
            m_dm = 32'h8081_7F82; m_load_type = lt[i]; m_byte_off = lo[i];
            tick($sformatf("load%0d", i));
        end

        // Jal link write, then link to $0 via rd
        set_op(1'b1, 1'b1, 2'd2, 2'd2, 5'd5, 5'd6);
        m_pc = 32'h0000_3000;
        tick("jal");
        set_op(1'b1, 1'b1, 2'd2, 2'd1, 5'd5, 5'd0);
        m_pc = 32'h0000_3000;
        tick("jal_r0");

        // Stall holding an ALU write, then stall+flush, then an invalid slot
        set_op(1'b1, 1'b1, 2'd1, 2'd1, 5'd2, 5'd7);
        m_alu = 32'h0000_1234;
        tick("alu");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, 1'b1, 2'd1, 2'd0, 5'($urandom), 5'($urandom));
            tick("stall");
        end
        flush = 1'b1;
        tick("stall_flush");
        stall = 1'b0; flush = 1'b0;
        set_op(1'b0, 1'b1, 2'd1, 2'd0, 5'd8, 5'd8);
        tick("invalid");

        // HI/LO source
        set_op(1'b1, 1'b1, 2'd3, 2'd1, 5'd1, 5'd12);
        m_hilo = 32'hDEAD_BEEF;
        tick("hilo");

        // Reset under flush, then counter wrap after 17 valid captures
        flush = 1'b1; reset = 1'b1;
        tick("reset_flush");
        flush = 1'b0; reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_op(1'b1, 1'b1, 2'd1, 2'd0, 5'($urandom), 5'($urandom));
            tick("wrap");
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            set_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
                   5'($urandom), 5'($urandom));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick("random");
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
